regfile_writeback_queue: RTL

Producer-side write initiator for nbit_register_file.
- Accepts register writes from execute/memory stages through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file write port (WriteData/WriteSelect/WriteEnable).
- Provides two combinational bypass lookups so readers see writes that are still pending and not yet committed to the register file.

---
 rtl/regfile_writeback_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// Write-back queue that buffers register writes and drains one per cycle onto the
// register file write port, with two bypass lookups over the writes not yet committed.
module regfile_writeback_queue #(
    parameter int REG_SELECT_WIDTH = 5,
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_LOG2       = 2
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [REG_SELECT_WIDTH-1:0] InSelect,
    input  logic [DATA_WIDTH-1:0]       InData,
    input  logic                        Stall,
    output logic [DATA_WIDTH-1:0]       WriteData,
    output logic [REG_SELECT_WIDTH-1:0] WriteSelect,
    output logic                        WriteEnable,
    input  logic [REG_SELECT_WIDTH-1:0] LookupSelect1,
    output logic                        LookupHit1,
    output logic [DATA_WIDTH-1:0]       LookupData1,
    input  logic [REG_SELECT_WIDTH-1:0] LookupSelect2,
    output logic                        LookupHit2,
    output logic [DATA_WIDTH-1:0]       LookupData2,
    output logic [DEPTH_LOG2:0]         Count,
    output logic                        Empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [REG_SELECT_WIDTH-1:0] sel_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]       data_mem [DEPTH];

    logic [DEPTH_LOG2-1:0]       head_p0;
    logic [DEPTH_LOG2-1:0]       tail_p0;
    logic [DEPTH_LOG2:0]         count_p0;

    logic                        vld_p1;
    logic [REG_SELECT_WIDTH-1:0] sel_p1;
    logic [DATA_WIDTH-1:0]       data_p1;

    logic accept;
    logic store;
    logic drain;

    assign InReady = (count_p0 < FULL_COUNT);
    assign accept  = InValid && InReady;
    // Register 0 is hard-wired in the register file, so its writes complete the handshake but are dropped.
    assign store   = accept && (InSelect != '0);
    assign drain   = !Stall && (count_p0 != '0);

    // Stage p0: FIFO storage and pointers
    always_ff @(posedge Clk) begin
        if (store) begin
            sel_mem[tail_p0]  <= InSelect;
            data_mem[tail_p0] <= InData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_p0  <= '0;
            tail_p0  <= '0;
            count_p0 <= '0;
        end else begin
            if (store) begin
                tail_p0 <= tail_p0 + PTR_ONE;
            end
            if (drain) begin
                head_p0 <= head_p0 + PTR_ONE;
            end
            case ({store, drain})
                2'b10:   count_p0 <= count_p0 + CNT_ONE;
                2'b01:   count_p0 <= count_p0 - CNT_ONE;
                default: count_p0 <= count_p0;
            endcase
        end
    end

    // Stage p1: register-file write port
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p1  <= 1'b0;
            sel_p1  <= '0;
            data_p1 <= '0;
        end else if (drain) begin
            vld_p1  <= 1'b1;
            sel_p1  <= sel_mem[head_p0];
            data_p1 <= data_mem[head_p0];
        end else begin
            vld_p1  <= 1'b0;
        end
    end

    assign WriteEnable = vld_p1;
    assign WriteSelect = sel_p1;
    assign WriteData   = data_p1;
    assign Count       = count_p0;
    assign Empty       = (count_p0 == '0) && !vld_p1;

    // Oldest candidate is applied first so each newer match overrides it.
    always_comb begin
        logic [DEPTH_LOG2-1:0] idx;
        LookupHit1  = 1'b0;
        LookupData1 = '0;
        LookupHit2  = 1'b0;
        LookupData2 = '0;
        idx         = head_p0;
        if (vld_p1 && (sel_p1 == LookupSelect1) && (LookupSelect1 != '0)) begin
            LookupHit1  = 1'b1;
            LookupData1 = data_p1;
        end
        if (vld_p1 && (sel_p1 == LookupSelect2) && (LookupSelect2 != '0)) begin
            LookupHit2  = 1'b1;
            LookupData2 = data_p1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_p0 + DEPTH_LOG2'(i);
            if ((DEPTH_LOG2 + 1)'(i) < count_p0) begin
                if ((sel_mem[idx] == LookupSelect1) && (LookupSelect1 != '0)) begin
                    LookupHit1  = 1'b1;
                    LookupData1 = data_mem[idx];
                end
                if ((sel_mem[idx] == LookupSelect2) && (LookupSelect2 != '0)) begin
                    LookupHit2  = 1'b1;
                    LookupData2 = data_mem[idx];
                end
            end
        end
    end

endmodule
